// File: rtl/stream_sched_pkg.sv
// Shared types and constants for the round-robin stream-core scheduler slice.
package stream_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN,
    DONE
  } sched_state_t;

  localparam int unsigned DEF_NREQ  = 4;
  localparam int unsigned DEF_BURST = 8;

  function automatic int unsigned id_width(input int unsigned n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/stream_core_scheduler_if.sv
// Requester channels plus the shared-core port, bundled for the scheduler.
interface stream_core_scheduler_if
  import stream_sched_pkg::*;
#(
  parameter int unsigned NREQ = DEF_NREQ
);
  logic [NREQ-1:0]             req;
  logic [NREQ-1:0]             req_in;
  logic [NREQ-1:0]             grant;
  logic [NREQ-1:0]             done;
  logic                        out_bit;
  logic                        out_valid;
  logic [id_width(NREQ)-1:0]   out_id;
  logic                        busy;
  logic                        dev_rst;
  logic                        dev_in;
  logic                        dev_out;
  logic                        dev_cont;

  modport master (
    output req, req_in, dev_out, dev_cont,
    input  grant, done, out_bit, out_valid, out_id, busy, dev_rst, dev_in
  );

  modport slave (
    input  req, req_in, dev_out, dev_cont,
    output grant, done, out_bit, out_valid, out_id, busy, dev_rst, dev_in
  );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_pick
  import stream_sched_pkg::*;
#(
  parameter  int unsigned NREQ = DEF_NREQ,
  localparam int unsigned IW   = id_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            found,
  output logic [IW-1:0]   idx
);

  logic [IW:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      // one extra bit holds ptr+i before folding back below NREQ
      cand = {1'b0, ptr} + (IW+1)'(i);
      if (cand >= (IW+1)'(NREQ)) cand = cand - (IW+1)'(NREQ);
      if (!found && req[cand[IW-1:0]]) begin
        found = 1'b1;
        idx   = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/stream_core_scheduler.sv
// Time-shares one single-bit stream core among NREQ requesters in round-robin bursts.
module stream_core_scheduler
  import stream_sched_pkg::*;
#(
  parameter int unsigned NREQ  = DEF_NREQ,
  parameter int unsigned BURST = DEF_BURST
) (
  input  logic                   clk,
  input  logic                   rst,
  stream_core_scheduler_if.slave bus
);

  localparam int unsigned    IW     = id_width(NREQ);
  localparam int unsigned    CW     = $clog2(BURST) + 1;
  localparam logic [CW-1:0]  LAST   = CW'(BURST - 1);
  localparam logic [IW-1:0]  TOP_ID = IW'(NREQ - 1);

  sched_state_t    state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   grant_id;
  logic [CW-1:0]   cnt;
  logic [NREQ-1:0] grant_q;
  logic [NREQ-1:0] done_q;
  logic            busy_q;
  logic            out_bit_q;
  logic            out_valid_q;
  logic [IW-1:0]   out_id_q;
  logic            pick_found;
  logic [IW-1:0]   pick_id;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (bus.req),
    .ptr   (ptr),
    .found (pick_found),
    .idx   (pick_id)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      ptr         <= '0;
      grant_id    <= '0;
      cnt         <= '0;
      grant_q     <= '0;
      done_q      <= '0;
      busy_q      <= 1'b0;
      out_bit_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
    end else begin
      out_valid_q <= (state == RUN);
      out_bit_q   <= bus.dev_out;
      out_id_q    <= grant_id;
      done_q      <= '0;
      unique case (state)
        IDLE: begin
          if (pick_found) begin
            grant_id <= pick_id;
            grant_q  <= {{(NREQ-1){1'b0}}, 1'b1} << pick_id;
            busy_q   <= 1'b1;
            state    <= PRIME;
          end
        end
        PRIME: begin
          cnt   <= '0;
          state <= RUN;
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST || !bus.dev_cont) begin
            done_q <= grant_q;
            state  <= DONE;
          end
        end
        DONE: begin
          ptr     <= (grant_id == TOP_ID) ? '0 : grant_id + 1'b1;
          grant_q <= '0;
          busy_q  <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.grant     = grant_q;
  assign bus.done      = done_q;
  assign bus.busy      = busy_q;
  assign bus.out_bit   = out_bit_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_id    = out_id_q;
  // the core must also be held in reset while this block is in reset
  assign bus.dev_rst   = !rst || (state == PRIME);
  assign bus.dev_in    = (state == RUN) ? bus.req_in[grant_id] : 1'b0;

endmodule

// File: tb/tb_stream_core_scheduler.sv
// Randomized scoreboard bench for stream_core_scheduler with an echoing core model.
module tb_stream_core_scheduler;
  import stream_sched_pkg::*;

  localparam int NREQ  = 4;
  localparam int BURST = 8;

  typedef struct {
    logic b;
    int   id;
    bit   last;
  } item_t;

  logic clk;
  logic rst;

  stream_core_scheduler_if #(.NREQ(NREQ)) bus ();

  stream_core_scheduler #(.NREQ(NREQ), .BURST(BURST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // core model: output follows input combinationally
  assign bus.dev_out = bus.dev_in;

  item_t exp_q[$];
  int    n_checks   = 0;
  int    n_fail     = 0;
  bit    ignore_out = 0;
  bit    in_done    = 0;
  int    model_ptr  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr_model(input logic [NREQ-1:0] m, input int p);
    for (int i = 0; i < NREQ; i++)
      if (m[(p + i) % NREQ]) return (p + i) % NREQ;
    return -1;
  endfunction

  task automatic run_txn(input logic [NREQ-1:0] mask, input int gap, input int stop,
                         input bit drop, input int rst_at, input bit use_pat,
                         input logic [31:0] pat);
    int              win;
    int              lat;
    int              len;
    bit              got;
    logic [NREQ-1:0] vec;
    item_t           it;
    if (gap > 0) begin
      bus.req = '0;
      repeat (gap) @(negedge clk);
    end
    bus.req = mask;
    win = rr_model(mask, model_ptr);
    got = 0;
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (bus.grant != '0) begin
        lat = k;
        got = 1;
        break;
      end
    end
    chk("grant_latency", lat, (in_done && gap == 0) ? 2 : 1);
    in_done = 0;
    if (!got) return;
    chk("grant_onehot", bus.grant, 1 << win);
    chk("prime_dev_rst", bus.dev_rst, 1);
    chk("prime_busy", bus.busy, 1);
    len = (stop >= 0 && stop < BURST) ? stop + 1 : BURST;
    for (int j = 0; j < len; j++) begin
      @(posedge clk);
      #1;
      if (j == rst_at) begin
        ignore_out = 1;
        rst = 1'b0;
        exp_q.delete();
        #1;
        chk("rst_grant", bus.grant, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_bit", bus.out_bit, 0);
        chk("rst_out_id", bus.out_id, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_dev_in", bus.dev_in, 0);
        chk("rst_dev_rst", bus.dev_rst, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_hold_done", bus.done, 0);
        chk("rst_hold_dev_rst", bus.dev_rst, 1);
        rst = 1'b1;
        ignore_out = 0;
        #1;
        chk("rst_release_dev_rst", bus.dev_rst, 0);
        model_ptr = 0;
        in_done = 0;
        return;
      end
      vec = NREQ'($urandom);
      if (use_pat) vec[win] = pat[j];
      bus.req_in   = vec;
      bus.dev_cont = (j == stop) ? 1'b0 : 1'b1;
      if (drop && j == 1) bus.req = '0;
      it.b    = vec[win];
      it.id   = win;
      it.last = (j == len - 1);
      exp_q.push_back(it);
      #1;
      chk("dev_in_steer", bus.dev_in, vec[win]);
      chk("run_dev_rst", bus.dev_rst, 0);
    end
    @(posedge clk);
    #1;
    bus.dev_cont = 1'b1;
    bus.req_in   = NREQ'($urandom);
    @(negedge clk);
    chk("done_busy", bus.busy, 1);
    chk("done_grant", bus.grant, 1 << win);
    chk("done_dev_in_zero", bus.dev_in, 0);
    model_ptr = (win + 1) % NREQ;
    in_done = 1;
  endtask

  initial begin
    item_t it;
    forever begin
      @(negedge clk);
      if (rst && !ignore_out) begin
        if (bus.out_valid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_out_valid", bus.out_valid, 0);
          end else begin
            it = exp_q.pop_front();
            chk("out_bit", bus.out_bit, it.b);
            chk("out_id", bus.out_id, it.id);
            chk("done_with_out", bus.done, it.last ? (1 << it.id) : 0);
          end
        end else begin
          chk("done_without_out", bus.done, 0);
        end
      end
    end
  end

  initial begin
    logic [NREQ-1:0] m;
    int              st;
    rst          = 1'b1;
    bus.req      = '0;
    bus.req_in   = '0;
    bus.dev_cont = 1'b1;
    #1 rst = 1'b0;
    #2;
    chk("reset_grant", bus.grant, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_out_bit", bus.out_bit, 0);
    chk("reset_out_id", bus.out_id, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_dev_in", bus.dev_in, 0);
    chk("reset_dev_rst", bus.dev_rst, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("release_dev_rst", bus.dev_rst, 0);

    run_txn(4'b0100, 0, -1, 0, -1, 0, 0);
    repeat (5) run_txn(4'b1111, 0, -1, 0, -1, 0, 0);
    run_txn(4'b0001, 0, 2, 0, -1, 0, 0);
    run_txn(4'b0010, 0, -1, 1, -1, 0, 0);
    run_txn(4'b0100, 0, -1, 0, -1, 0, 0);
    run_txn(4'b1010, 0, -1, 0, 4, 0, 0);
    run_txn(4'b1010, 2, -1, 0, -1, 0, 0);
    run_txn(4'b1000, 0, -1, 0, -1, 0, 0);
    run_txn(4'b0001, 1, -1, 0, -1, 1, 32'h0000_000D);

    for (int n = 0; n < 40; n++) begin
      do m = NREQ'($urandom); while (m == '0);
      st = ($urandom_range(1, 0) == 1) ? int'($urandom_range(BURST - 1, 0)) : -1;
      run_txn(m, $urandom_range(3, 0), st, $urandom_range(1, 0) == 1, -1, 0, 0);
    end

    bus.req = '0;
    repeat (5) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("final_busy", bus.busy, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
